// File: rtl/collision_pkg.sv
// Shared types and sizing for the T-rex vs obstacle collision detector.
//   collision_box_t : box relative to an owner origin (unsigned x, y, width, height)
//   abs_box_t       : absolute box, signed 12-bit x, unsigned 11-bit y
//   to_abs()        : offsets a relative box by an absolute origin
//   state_t         : scan FSM states
package collision_pkg;

  localparam int unsigned MAX_OBSTACLES      = 2;
  localparam int unsigned TREX_BOX_COUNT     = 6;
  localparam int unsigned OBSTACLE_BOX_COUNT = 5;

  localparam int unsigned IDX_W = (MAX_OBSTACLES > 1)      ? $clog2(MAX_OBSTACLES)      : 1;
  localparam int unsigned T_W   = (TREX_BOX_COUNT > 1)     ? $clog2(TREX_BOX_COUNT)     : 1;
  localparam int unsigned O_W   = (OBSTACLE_BOX_COUNT > 1) ? $clog2(OBSTACLE_BOX_COUNT) : 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] width;
    logic [9:0] height;
  } collision_box_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic [10:0]        y;
    logic [9:0]         w;
    logic [9:0]         h;
  } abs_box_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COARSE,
    ST_FINE,
    ST_DONE
  } state_t;

  function automatic abs_box_t to_abs(input abs_box_t origin, input collision_box_t box);
    abs_box_t r;
    r.x = origin.x + $signed({2'b00, box.x});
    r.y = origin.y + {1'b0, box.y};
    r.w = box.width;
    r.h = box.height;
    return r;
  endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Bus between the game logic (master) and collision_detector (slave).
//   update/enable          : frame-update pulse and game-running qualifier
//   trex_*                 : trex outer box and inner boxes (relative)
//   obstacle_*             : per-slot obstacle outer box and inner boxes; width 0 = empty
//   busy/done/crash/crash_obstacle : scan status and result
interface collision_detector_if;
  import collision_pkg::*;

  logic                                                        update;
  logic                                                        enable;
  logic [9:0]                                                  trex_x_pos;
  logic [9:0]                                                  trex_y_pos;
  logic [9:0]                                                  trex_width;
  logic [9:0]                                                  trex_height;
  collision_box_t [TREX_BOX_COUNT-1:0]                         trex_box;
  logic [MAX_OBSTACLES-1:0][10:0]                              obstacle_x_pos;
  logic [MAX_OBSTACLES-1:0][9:0]                               obstacle_y_pos;
  logic [MAX_OBSTACLES-1:0][9:0]                               obstacle_width;
  logic [MAX_OBSTACLES-1:0][9:0]                               obstacle_height;
  collision_box_t [MAX_OBSTACLES-1:0][OBSTACLE_BOX_COUNT-1:0]  obstacle_box;
  logic                                                        busy;
  logic                                                        done;
  logic                                                        crash;
  logic [IDX_W-1:0]                                            crash_obstacle;

  modport master (
    output update, enable,
    output trex_x_pos, trex_y_pos, trex_width, trex_height, trex_box,
    output obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height, obstacle_box,
    input  busy, done, crash, crash_obstacle
  );

  modport slave (
    input  update, enable,
    input  trex_x_pos, trex_y_pos, trex_width, trex_height, trex_box,
    input  obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height, obstacle_box,
    output busy, done, crash, crash_obstacle
  );

endinterface

// File: rtl/box_overlap.sv
// Combinational strict-overlap test of two absolute boxes.
//   i_a, i_b : absolute boxes
//   o_hit    : 1 when the interiors overlap; touching edges and zero-size boxes never hit
module box_overlap
  import collision_pkg::*;
(
  input  abs_box_t i_a,
  input  abs_box_t i_b,
  output logic     o_hit
);

  logic signed [11:0] w_ax, w_bx, w_ax_end, w_bx_end;
  logic signed [11:0] w_ay, w_by, w_ay_end, w_by_end;
  logic               w_nonzero;

  always_comb begin
    w_ax      = i_a.x;
    w_bx      = i_b.x;
    w_ax_end  = w_ax + $signed({2'b00, i_a.w});
    w_bx_end  = w_bx + $signed({2'b00, i_b.w});
    w_ay      = $signed({1'b0, i_a.y});
    w_by      = $signed({1'b0, i_b.y});
    w_ay_end  = w_ay + $signed({2'b00, i_a.h});
    w_by_end  = w_by + $signed({2'b00, i_b.h});
    // Strict compares alone would let a zero-width box sitting inside the other hit.
    w_nonzero = (i_a.w != '0) && (i_a.h != '0) && (i_b.w != '0) && (i_b.h != '0);
    o_hit     = w_nonzero && (w_ax < w_bx_end) && (w_bx < w_ax_end)
                          && (w_ay < w_by_end) && (w_by < w_ay_end);
  end

endmodule

// File: rtl/collision_detector.sv
// Per-frame T-rex vs obstacle hit test. One cycle after each enabled update pulse the
// trex/obstacle inputs are snapshotted, then each obstacle slot gets a coarse outer-box
// check followed, on a coarse hit, by a fine scan of every trex/obstacle inner box pair.
//   clk, rst_n : clock, synchronous active-low reset
//   io (slave) : update/enable in, trex_*/obstacle_* in, busy/done/crash/crash_obstacle out
// Build option: COLLISION_EARLY_EXIT_EN ends the scan at the first fine pair hit.
module collision_detector
  import collision_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  collision_detector_if.slave  io
);

  state_t r_state, w_state_nxt;
  logic   r_update_q;

  logic [9:0]                                                  r_trex_x, r_trex_y, r_trex_w, r_trex_h;
  collision_box_t [TREX_BOX_COUNT-1:0]                         r_trex_box;
  logic [MAX_OBSTACLES-1:0][10:0]                              r_obs_x;
  logic [MAX_OBSTACLES-1:0][9:0]                               r_obs_y, r_obs_w, r_obs_h;
  collision_box_t [MAX_OBSTACLES-1:0][OBSTACLE_BOX_COUNT-1:0]  r_obs_box;

  logic [IDX_W-1:0] r_i, w_i_nxt, r_hit_idx, w_hit_idx_nxt, r_crash_idx;
  logic [T_W-1:0]   r_t, w_t_nxt;
  logic [O_W-1:0]   r_o, w_o_nxt;
  logic             r_hit_flag, w_hit_flag_nxt, r_crash;
  logic             w_snap, w_early_stop;
  logic             w_last_i, w_last_t, w_last_o;

  abs_box_t w_trex_outer, w_obs_outer, w_trex_fine, w_obs_fine;
  logic     w_coarse_hit, w_fine_hit;

  always_comb begin
    w_trex_outer.x = $signed({2'b00, r_trex_x});
    w_trex_outer.y = {1'b0, r_trex_y};
    w_trex_outer.w = r_trex_w;
    w_trex_outer.h = r_trex_h;
    w_obs_outer.x  = $signed({r_obs_x[r_i][10], r_obs_x[r_i]});
    w_obs_outer.y  = {1'b0, r_obs_y[r_i]};
    w_obs_outer.w  = r_obs_w[r_i];
    w_obs_outer.h  = r_obs_h[r_i];
    w_trex_fine    = to_abs(w_trex_outer, r_trex_box[r_t]);
    w_obs_fine     = to_abs(w_obs_outer, r_obs_box[r_i][r_o]);
  end

  box_overlap u_coarse (.i_a(w_trex_outer), .i_b(w_obs_outer), .o_hit(w_coarse_hit));
  box_overlap u_fine   (.i_a(w_trex_fine),  .i_b(w_obs_fine),  .o_hit(w_fine_hit));

  assign w_last_i = (r_i == IDX_W'(MAX_OBSTACLES - 1));
  assign w_last_t = (r_t == T_W'(TREX_BOX_COUNT - 1));
  assign w_last_o = (r_o == O_W'(OBSTACLE_BOX_COUNT - 1));

`ifdef COLLISION_EARLY_EXIT_EN
  assign w_early_stop = w_fine_hit;
`else
  assign w_early_stop = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_t_nxt        = r_t;
    w_o_nxt        = r_o;
    w_hit_flag_nxt = r_hit_flag;
    w_hit_idx_nxt  = r_hit_idx;
    w_snap         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_update_q && io.enable) begin
          w_snap         = 1'b1;
          w_state_nxt    = ST_COARSE;
          w_i_nxt        = '0;
          w_t_nxt        = '0;
          w_o_nxt        = '0;
          w_hit_flag_nxt = 1'b0;
          w_hit_idx_nxt  = '0;
        end
      end
      ST_COARSE: begin
        if ((r_obs_w[r_i] != '0) && w_coarse_hit) begin
          w_state_nxt = ST_FINE;
          w_t_nxt     = '0;
          w_o_nxt     = '0;
        end else if (w_last_i) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_i_nxt = r_i + 1'b1;
        end
      end
      ST_FINE: begin
        if (w_fine_hit) begin
          w_hit_flag_nxt = 1'b1;
          if (!r_hit_flag) w_hit_idx_nxt = r_i;
        end
        if (w_early_stop) begin
          w_state_nxt = ST_DONE;
        end else if (!w_last_o) begin
          w_o_nxt = r_o + 1'b1;
        end else begin
          w_o_nxt = '0;
          if (!w_last_t) begin
            w_t_nxt = r_t + 1'b1;
          end else begin
            w_t_nxt = '0;
            if (w_last_i) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_i_nxt     = r_i + 1'b1;
              w_state_nxt = ST_COARSE;
            end
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_update_q  <= 1'b0;
      r_i         <= '0;
      r_t         <= '0;
      r_o         <= '0;
      r_hit_flag  <= 1'b0;
      r_hit_idx   <= '0;
      r_crash     <= 1'b0;
      r_crash_idx <= '0;
      r_trex_x    <= '0;
      r_trex_y    <= '0;
      r_trex_w    <= '0;
      r_trex_h    <= '0;
      r_trex_box  <= '0;
      r_obs_x     <= '0;
      r_obs_y     <= '0;
      r_obs_w     <= '0;
      r_obs_h     <= '0;
      r_obs_box   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_update_q <= io.update;
      r_i        <= w_i_nxt;
      r_t        <= w_t_nxt;
      r_o        <= w_o_nxt;
      r_hit_flag <= w_hit_flag_nxt;
      r_hit_idx  <= w_hit_idx_nxt;
      if (w_snap) begin
        r_trex_x   <= io.trex_x_pos;
        r_trex_y   <= io.trex_y_pos;
        r_trex_w   <= io.trex_width;
        r_trex_h   <= io.trex_height;
        r_trex_box <= io.trex_box;
        r_obs_x    <= io.obstacle_x_pos;
        r_obs_y    <= io.obstacle_y_pos;
        r_obs_w    <= io.obstacle_width;
        r_obs_h    <= io.obstacle_height;
        r_obs_box  <= io.obstacle_box;
      end
      if (r_state == ST_DONE) begin
        r_crash     <= r_hit_flag;
        r_crash_idx <= r_hit_idx;
      end
    end
  end

  // Result registers load at the end of DONE; bypass them during DONE so the
  // result is already valid in the done cycle and held afterwards.
  assign io.busy           = (r_state != ST_IDLE);
  assign io.done           = (r_state == ST_DONE);
  assign io.crash          = (r_state == ST_DONE) ? r_hit_flag : r_crash;
  assign io.crash_obstacle = (r_state == ST_DONE) ? r_hit_idx  : r_crash_idx;

endmodule

// File: tb/tb_collision_detector.sv
module tb_collision_detector;
  import collision_pkg::*;

  typedef struct {
    bit crash;
    int idx;
    int lat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  collision_detector_if bus();
  collision_detector dut (.clk(clk), .rst_n(rst_n), .io(bus));

  res_t exp_q[$];
  res_t obs_q[$];
  int   cyc = 0;
  int   u_cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.done === 1'b1)
      obs_q.push_back('{crash: bus.crash, idx: int'(bus.crash_obstacle), lat: cyc - u_cyc});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit ov(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
    return (aw > 0) && (ah > 0) && (bw > 0) && (bh > 0) &&
           (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  // Reference scan over the inputs the bench is driving.
  function automatic res_t model();
    res_t r;
    int c, tx, ty, ox, oy;
    r.crash = 1'b0; r.idx = 0; c = 1;
    tx = int'(bus.trex_x_pos); ty = int'(bus.trex_y_pos);
    for (int i = 0; i < int'(MAX_OBSTACLES); i++) begin
      c++;
      ox = int'($signed(bus.obstacle_x_pos[i]));
      oy = int'(bus.obstacle_y_pos[i]);
      if (ov(tx, ty, int'(bus.trex_width), int'(bus.trex_height),
             ox, oy, int'(bus.obstacle_width[i]), int'(bus.obstacle_height[i]))) begin
        for (int t = 0; t < int'(TREX_BOX_COUNT); t++) begin
          for (int o = 0; o < int'(OBSTACLE_BOX_COUNT); o++) begin
            c++;
            if (ov(tx + int'(bus.trex_box[t].x), ty + int'(bus.trex_box[t].y),
                   int'(bus.trex_box[t].width), int'(bus.trex_box[t].height),
                   ox + int'(bus.obstacle_box[i][o].x), oy + int'(bus.obstacle_box[i][o].y),
                   int'(bus.obstacle_box[i][o].width), int'(bus.obstacle_box[i][o].height))) begin
              if (!r.crash) r.idx = i;
              r.crash = 1'b1;
`ifdef COLLISION_EARLY_EXIT_EN
              r.lat = c + 1;
              return r;
`endif
            end
          end
        end
      end
    end
    r.lat = c + 1;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.update          = 1'b0;
    bus.enable          = 1'b1;
    bus.trex_x_pos      = 10'd50;
    bus.trex_y_pos      = 10'd93;
    bus.trex_width      = 10'd44;
    bus.trex_height     = 10'd47;
    bus.trex_box        = '0;
    bus.trex_box[0]     = '{x: 10'd0, y: 10'd0, width: 10'd44, height: 10'd47};
    bus.obstacle_x_pos  = '0;
    bus.obstacle_y_pos  = '0;
    bus.obstacle_width  = '0;
    bus.obstacle_height = '0;
    bus.obstacle_box    = '0;
  endtask

  // Places an obstacle whose inner box 0 covers its whole outer box.
  task automatic set_obs(input int i, input int x, input int y, input int w, input int h);
    bus.obstacle_x_pos[i]  = 11'(x);
    bus.obstacle_y_pos[i]  = 10'(y);
    bus.obstacle_width[i]  = 10'(w);
    bus.obstacle_height[i] = 10'(h);
    bus.obstacle_box[i]    = '0;
    bus.obstacle_box[i][0] = '{x: 10'd0, y: 10'd0, width: 10'(w), height: 10'(h)};
  endtask

  // Pulses update for one cycle (cycle U) and records the expected result.
  task automatic launch();
    exp_q.push_back(model());
    @(posedge clk); #1;
    bus.update = 1'b1;
    u_cyc = cyc;
    @(posedge clk); #1;
    bus.update = 1'b0;
  endtask

  task automatic get_result(output res_t e, output res_t o, output bit ok);
    ok = 1'b0;
    repeat (200) begin
      @(negedge clk); #1;
      if (obs_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    if (ok) o = obs_q.pop_front();
    else    o = '{crash: 1'b0, idx: -1, lat: -1};
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.crash, bus.crash_obstacle} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b crash=%b idx=%0d, expected all 0",
               bus.busy, bus.done, bus.crash, bus.crash_obstacle);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_coarse();
    res_t e, o; bit ok;
    for (int k = 0; k < 2; k++) begin
      set_defaults();
      if (k == 1) set_obs(0, 200, 105, 17, 35);
      launch();
      get_result(e, o, ok);
      tests++;
      if (!ok || o.crash !== e.crash || e.crash !== 1'b0) begin
        fails++; $display("FAIL coarse%0d_crash: got %0d expected 0 (timeout=%0d)", k, o.crash, !ok);
      end
      tests++;
      if (o.lat !== e.lat || e.lat !== 4) begin
        fails++; $display("FAIL coarse%0d_latency: got %0d expected 4", k, o.lat);
      end
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0) begin
        fails++; $display("FAIL coarse%0d_busy_after: got %b expected 0", k, bus.busy);
      end
      idle(2);
    end
  endtask

  task automatic test_fine();
    res_t e, o; bit ok;
    for (int k = 0; k < 2; k++) begin
      set_defaults();
      if (k == 0) begin
        set_obs(1, 60, 105, 17, 35);
      end else begin
        bus.trex_box[0] = '{x: 10'd0, y: 10'd0, width: 10'd30, height: 10'd47};
        set_obs(0, 90, 105, 17, 35);
        bus.obstacle_box[0][0] = '{x: 10'd5, y: 10'd0, width: 10'd12, height: 10'd35};
      end
      launch();
      get_result(e, o, ok);
      tests++;
      if (!ok || o.crash !== e.crash) begin
        fails++; $display("FAIL fine%0d_crash: got %0d expected %0d", k, o.crash, e.crash);
      end
      tests++;
      if (o.idx !== e.idx) begin
        fails++; $display("FAIL fine%0d_obstacle: got %0d expected %0d", k, o.idx, e.idx);
      end
      tests++;
      if (o.lat !== e.lat) begin
        fails++; $display("FAIL fine%0d_latency: got %0d expected %0d", k, o.lat, e.lat);
      end
      idle(2);
    end
  endtask

  task automatic test_edges();
    res_t e, o; bit ok;
    for (int k = 0; k < 3; k++) begin
      set_defaults();
      case (k)
        0: set_obs(0, 94, 105, 17, 35);
        1: set_obs(0, 93, 105, 17, 35);
        default: begin
          bus.trex_x_pos = 10'd0;
          set_obs(0, -20, 105, 25, 35);
        end
      endcase
      launch();
      get_result(e, o, ok);
      tests++;
      if (!ok || o.crash !== e.crash || e.crash !== (k != 0)) begin
        fails++; $display("FAIL edge%0d_crash: got %0d expected %0d", k, o.crash, (k != 0));
      end
      tests++;
      if (o.idx !== e.idx || o.lat !== e.lat) begin
        fails++; $display("FAIL edge%0d_idx_lat: got %0d/%0d expected %0d/%0d",
                          k, o.idx, o.lat, e.idx, e.lat);
      end
      idle(2);
    end
  endtask

  task automatic test_enable();
    res_t e, o; bit ok;
    set_defaults();
    set_obs(0, 60, 105, 17, 35);
    bus.enable = 1'b0;
    @(posedge clk); #1; bus.update = 1'b1;
    @(posedge clk); #1; bus.update = 1'b0;
    idle(40);
    tests++;
    if (obs_q.size() !== 0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL enable_low_ignored: dones=%0d busy=%b expected 0/0", obs_q.size(), bus.busy);
    end
    obs_q.delete();
    bus.enable = 1'b1;
    launch();
    @(posedge clk); #1;
    bus.enable = 1'b0;
    get_result(e, o, ok);
    tests++;
    if (!ok || o.crash !== e.crash || o.lat !== e.lat) begin
      fails++; $display("FAIL enable_fall_mid_scan: got crash=%0d lat=%0d expected %0d/%0d",
                        o.crash, o.lat, e.crash, e.lat);
    end
    bus.enable = 1'b1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    res_t e, o; bit ok;
    set_defaults();
    set_obs(1, 60, 105, 17, 35);
    launch();
    @(posedge clk); #1; bus.update = 1'b1;
    @(posedge clk); #1; bus.update = 1'b0;
    get_result(e, o, ok);
    tests++;
    if (!ok || o.crash !== e.crash || o.idx !== e.idx || o.lat !== e.lat) begin
      fails++; $display("FAIL retrigger_result: got %0d/%0d/%0d expected %0d/%0d/%0d",
                        o.crash, o.idx, o.lat, e.crash, e.idx, e.lat);
    end
    idle(60);
    tests++;
    if (obs_q.size() !== 0) begin
      fails++; $display("FAIL retrigger_single_done: extra dones=%0d expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_scan();
    res_t e, o; bit ok;
    set_defaults();
    set_obs(1, 60, 105, 17, 35);
    launch();
    void'(exp_q.pop_back());
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.crash !== 1'b0 || bus.crash_obstacle !== '0) begin
      fails++; $display("FAIL reset_mid_scan_outputs: busy=%b done=%b crash=%b idx=%0d expected all 0",
                        bus.busy, bus.done, bus.crash, bus.crash_obstacle);
    end
    idle(50);
    tests++;
    if (obs_q.size() !== 0) begin
      fails++; $display("FAIL reset_mid_scan_no_done: dones=%0d expected 0", obs_q.size());
    end
    obs_q.delete();
    launch();
    get_result(e, o, ok);
    tests++;
    if (!ok || o.crash !== e.crash || o.idx !== e.idx || o.lat !== e.lat) begin
      fails++; $display("FAIL post_reset_scan: got %0d/%0d/%0d expected %0d/%0d/%0d",
                        o.crash, o.idx, o.lat, e.crash, e.idx, e.lat);
    end
    idle(2);
  endtask

  initial begin
    set_defaults();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_coarse();
    test_fine();
    test_edges();
    test_enable();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
